seven_segment_scan: RTL and testbench

Parametrised multi-digit, time-multiplexed hex display driver. Successor to the single-digit combinational hex-to-7-segment decoder.
Latches a packed DIGITS×4-bit value and scans one digit per scan tick. Drives shared segment and decimal-point lines plus a one-hot digit-enable bus.
Sits between user logic and the board's display pins; per-digit blanking and decimal points are supported.

---
 rtl/seven_segment_scan.sv | 130 +++++++++++++
 tb/tb_seven_segment_scan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_scan
// Purpose : Time-multiplexed DIGITS-wide hex display driver with shadowed
//           value/dp/blank, registered outputs and selectable polarity.
//           Leading-zero blanking: define SEVEN_SEGMENT_SCAN_LZB_EN.
// Rev     : 1.0
// ============================================================================
module seven_segment_scan #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] c_cnt_max = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] c_idx_max = IW'(DIGITS - 1);
  localparam logic          c_inv     = ~ACTIVE_LOW;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  tick_q;
  logic [4*DIGITS-1:0]   val_q;
  logic [DIGITS-1:0]     dp_q, blank_q;
  logic [6:0]            seg_q;
  logic                  dpo_q;
  logic [DIGITS-1:0]     en_q;

  logic [DIGITS-1:0]     w_blank_vec;
  logic [3:0]            w_nib;
  logic                  w_blank, w_dp;
  logic [DIGITS-1:0]     w_onehot;
  logic [6:0]            w_seg_al;
  logic                  w_dp_al;

  // Active-low font; polarity is applied once at the output register.
  function automatic logic [6:0] font_al(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h40;  4'h1: f = 7'h79;  4'h2: f = 7'h24;  4'h3: f = 7'h30;
      4'h4: f = 7'h19;  4'h5: f = 7'h12;  4'h6: f = 7'h02;  4'h7: f = 7'h78;
      4'h8: f = 7'h00;  4'h9: f = 7'h10;  4'hA: f = 7'h08;  4'hB: f = 7'h03;
      4'hC: f = 7'h46;  4'hD: f = 7'h21;  4'hE: f = 7'h06;  default: f = 7'h0E;
    endcase
    return f;
  endfunction

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
  logic [DIGITS-1:0] w_lzb;
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    w_lzb      = '0;
    // Walk down from the top digit; digit 0 always stays lit.
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (val_q[4*i +: 4] == 4'h0);
      w_lzb[i]   = zero_above;
    end
  end
  assign w_blank_vec = blank_q | w_lzb;
`else
  assign w_blank_vec = blank_q;
`endif

  always_comb begin
    w_nib    = 4'h0;
    w_blank  = 1'b0;
    w_dp     = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        w_nib       = val_q[4*i +: 4];
        w_blank     = w_blank_vec[i];
        w_dp        = dp_q[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_seg_al = w_blank ? 7'h7F : font_al(w_nib);
  assign w_dp_al  = ~(w_dp & ~w_blank);

  assign cnt_d = (cnt_q == c_cnt_max) ? '0 : cnt_q + 1'b1;
  assign idx_d = tick_q ? ((idx_q == c_idx_max) ? '0 : idx_q + 1'b1) : idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      val_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      seg_q   <= 7'h7F ^ {7{c_inv}};
      dpo_q   <= 1'b1 ^ c_inv;
      en_q    <= {DIGITS{~c_inv}};
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == c_cnt_max);
      idx_q  <= idx_d;
      if (load) begin
        val_q   <= value;
        dp_q    <= dp_in;
        blank_q <= blank_in;
      end
      seg_q <= w_seg_al ^ {7{c_inv}};
      dpo_q <= w_dp_al ^ c_inv;
      en_q  <= ~w_onehot ^ {DIGITS{c_inv}};
    end
  end

  assign seg_out  = seg_q;
  assign dp_out   = dpo_q;
  assign digit_en = en_q;
  assign tick     = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_segment_scan
// Purpose : Directed self-checking bench for seven_segment_scan.
// Rev     : 1.0
// ============================================================================
module tb_seven_segment_scan;

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
  localparam logic [6:0] c_lz = 7'h7F;
`else
  localparam logic [6:0] c_lz = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [15:0] value0 = '0;
  logic        load0  = 1'b0;
  logic [3:0]  dpin0  = '0;
  logic [3:0]  blank0 = '0;
  logic [6:0]  seg0;
  logic        dp0;
  logic [3:0]  en0;
  logic        tick0;

  logic [3:0]  value1 = '0;
  logic        load1  = 1'b0;
  logic [0:0]  dpin1  = '0;
  logic [0:0]  blank1 = '0;
  logic [6:0]  seg1;
  logic        dp1;
  logic [0:0]  en1;
  logic        tick1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seven_segment_scan #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst(rst), .value(value0), .load(load0), .dp_in(dpin0),
    .blank_in(blank0), .seg_out(seg0), .dp_out(dp0), .digit_en(en0), .tick(tick0)
  );

  seven_segment_scan #(.DIGITS(1), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst(rst), .value(value1), .load(load1), .dp_in(dpin1),
    .blank_in(blank1), .seg_out(seg1), .dp_out(dp1), .digit_en(en1), .tick(tick1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_en(input logic [3:0] e);
    int n;
    n = 0;
    while (en0 !== e && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (en0 !== e) check("wait_en_timeout", {28'h0, en0}, {28'h0, e});
  endtask

  task automatic slot(input string tag, input logic [3:0] e, input logic [6:0] s, input logic d);
    int len;
    wait_en(e);
    check({tag, "_seg"}, {25'h0, seg0}, {25'h0, s});
    check({tag, "_dp"}, {31'h0, dp0}, {31'h0, d});
    len = 0;
    while (en0 === e && len < 40) begin
      @(negedge clk);
      len++;
    end
    check({tag, "_len"}, len, 4);
  endtask

  task automatic load_u0(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value0 = v; dpin0 = d; blank0 = b; load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
  endtask

  initial begin
    int cnt;
    int bad;

    // Reset state of both instances
    repeat (2) @(negedge clk);
    check("rst_seg0", {25'h0, seg0}, 32'h7F);
    check("rst_dp0", {31'h0, dp0}, 32'h1);
    check("rst_en0", {28'h0, en0}, 32'hF);
    check("rst_tick0", {31'h0, tick0}, 32'h0);
    check("rst_seg1", {25'h0, seg1}, 32'h00);
    check("rst_en1", {31'h0, en1}, 32'h0);
    check("rst_tick1", {31'h0, tick1}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-slot, then restart at digit 0
    #3 rst = 1'b1;
    #1;
    check("arst_seg", {25'h0, seg0}, 32'h7F);
    check("arst_dp", {31'h0, dp0}, 32'h1);
    check("arst_en", {28'h0, en0}, 32'hF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_en", {28'h0, en0}, 32'hE);
    check("restart_seg", {25'h0, seg0}, 32'h40);

    // Scan and font, value 1A3F
    load_u0(16'h1A3F, 4'b0000, 4'b0000);
    wait_en(4'h7);
    slot("d0", 4'hE, 7'h0E, 1'b1);
    slot("d1", 4'hD, 7'h30, 1'b1);
    slot("d2", 4'hB, 7'h08, 1'b1);
    slot("d3", 4'h7, 7'h79, 1'b1);
    slot("wrap", 4'hE, 7'h0E, 1'b1);
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (tick0 === 1'b1) cnt++;
    end
    check("tick_rate", cnt, 4);

    // Blank and decimal point
    load_u0(16'h1A3F, 4'b0010, 4'b1000);
    wait_en(4'h7);
    slot("b0", 4'hE, 7'h0E, 1'b1);
    slot("b1", 4'hD, 7'h30, 1'b0);
    slot("b2", 4'hB, 7'h08, 1'b1);
    slot("b3", 4'h7, 7'h7F, 1'b1);

    // Load coinciding with tick
    cnt = 0;
    while (tick0 !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("tick_seen", {31'h0, tick0}, 32'h1);
    load_u0(16'h0000, 4'b0000, 4'b0000);
    @(negedge clk);
    check("coll_seg", {25'h0, seg0}, 32'h40);
    check("coll_dp", {31'h0, dp0}, 32'h1);
    value0 = 16'hFFFF; dpin0 = 4'hF; blank0 = 4'hF;
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (seg0 !== 7'h40 || dp0 !== 1'b1) bad++;
    end
    check("no_stale_noload", bad, 0);

    // Single digit, active-high, SCAN_DIV=1
    value1 = 4'h8; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    @(negedge clk);
    check("ah_seg", {25'h0, seg1}, 32'h7F);
    check("ah_en", {31'h0, en1}, 32'h1);
    check("ah_dp", {31'h0, dp1}, 32'h0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (tick1 !== 1'b1) bad++;
    end
    check("ah_tick_const", bad, 0);

    // Leading-zero blanking (or plain zeros when the feature is absent)
    load_u0(16'h0050, 4'b0000, 4'b0000);
    wait_en(4'h7);
    slot("lz0", 4'hE, 7'h40, 1'b1);
    slot("lz1", 4'hD, 7'h12, 1'b1);
    slot("lz2", 4'hB, c_lz, 1'b1);
    slot("lz3", 4'h7, c_lz, 1'b1);
    load_u0(16'h0000, 4'b0000, 4'b0000);
    wait_en(4'h7);
    slot("z0", 4'hE, 7'h40, 1'b1);
    slot("z1", 4'hD, c_lz, 1'b1);
    slot("z3", 4'h7, c_lz, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
